// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one pipelined signed fixed-point multiplier
// among NUM_REQ requesters. Each requester may have one operation in flight,
// so responses return in issue order per requester. Pipeline: S1 operands,
// S2 full product, OUT quantized result; all three freeze while the current
// OUT owner withholds resp_ready.
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  input  logic [NUM_REQ-1:0]            resp_ready_i,
  output logic                          busy_o
);

  localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NUM_REQ - 1);

  logic                     s1_valid_q, s2_valid_q, out_valid_q;
  logic [DATA_WIDTH-1:0]    s1_a_q, s1_b_q;
  logic [TAG_W-1:0]         s1_tag_q, s2_tag_q, out_tag_q;
  logic signed [PROD_W-1:0] s2_prod_q, prod_d;
  logic [DATA_WIDTH-1:0]    out_data_q, quant_d;
  logic [NUM_REQ-1:0]       outstanding_q, outstanding_d;
  logic [TAG_W-1:0]         last_q, last_d;

  logic [NUM_REQ-1:0]       eligible;
  logic                     win_found;
  logic [TAG_W-1:0]         win_idx, cand;
  logic [DATA_WIDTH-1:0]    win_a, win_b;
  logic                     stall, accept, resp_fire;
  logic signed [PROD_W-1:0] a_ext, b_ext;

  assign eligible  = req_valid_i & ~outstanding_q;
  assign stall     = out_valid_q & ~resp_ready_i[out_tag_q];
  assign resp_fire = out_valid_q &  resp_ready_i[out_tag_q];
  assign accept    = |(req_valid_i & req_ready_o);
  assign win_a     = req_a_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_b     = req_b_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin search from last+1; scanning downward lets the nearest hit win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = TAG_W'((int'(last_q) + k) % NUM_REQ);
      if (eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant is withheld while stalled and while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (win_found && !stall && rst_ni) req_ready_o[win_idx] = 1'b1;
  end

  // Response side: one-hot valid steered by the OUT tag.
  always_comb begin
    resp_valid_o = '0;
    if (out_valid_q) resp_valid_o[out_tag_q] = 1'b1;
  end

  assign resp_data_o = out_data_q;
  assign busy_o      = s1_valid_q | s2_valid_q | out_valid_q;

  // Full-width signed product, then floor shift and wrap to the result width.
  always_comb begin
    a_ext   = {{DATA_WIDTH{s1_a_q[DATA_WIDTH-1]}}, s1_a_q};
    b_ext   = {{DATA_WIDTH{s1_b_q[DATA_WIDTH-1]}}, s1_b_q};
    prod_d  = a_ext * b_ext;
    quant_d = DATA_WIDTH'(s2_prod_q >>> QUANT_BITS);
  end

  // Outstanding flags and round-robin pointer next state; the clear of a
  // finishing tag and the set of a new grant never hit the same requester.
  always_comb begin
    outstanding_d = outstanding_q;
    if (resp_fire) outstanding_d[out_tag_q] = 1'b0;
    if (accept)    outstanding_d[win_idx]   = 1'b1;
    last_d = accept ? win_idx : last_q;
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      last_q        <= LAST_RST;
    end else begin
      outstanding_q <= outstanding_d;
      last_q        <= last_d;
    end
  end

  // Pipeline stages advance together unless the output owner stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (!stall) begin
      s1_valid_q  <= accept;
      s1_a_q      <= win_a;
      s1_b_q      <= win_b;
      s1_tag_q    <= win_idx;
      s2_valid_q  <= s1_valid_q;
      s2_prod_q   <= prod_d;
      s2_tag_q    <= s1_tag_q;
      out_valid_q <= s2_valid_q;
      out_data_q  <= quant_d;
      out_tag_q   <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int QB = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [DW-1:0] resp_data;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level reference: three-slot latency line, outstanding set, pointer.
  bit            m_v[3];
  int            m_tag[3];
  logic [DW-1:0] m_res[3];
  bit            m_out[N];
  int            m_last;

  logic [N-1:0]  obs_ready, obs_rvalid;
  logic [DW-1:0] obs_rdata;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .QUANT_BITS(QB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_a_i(req_a),
    .req_b_i(req_b), .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_data_o(resp_data), .resp_ready_i(resp_ready), .busy_o(busy));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] obs, logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] ref_mul(logic [DW-1:0] a, logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> QB;
    return p[DW-1:0];
  endfunction

  function automatic int ref_winner();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (req_valid[i] && !m_out[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit ref_stall();
    return m_v[2] && !resp_ready[m_tag[2]];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_tag[s] = 0; m_res[s] = '0; end
    for (int i = 0; i < N; i++) m_out[i] = 0;
    m_last = N - 1;
  endtask

  task automatic check_outputs();
    logic [N-1:0] er, ev;
    int w;
    er = '0; ev = '0;
    w = ref_winner();
    if (w >= 0 && !ref_stall()) er[w] = 1'b1;
    if (m_v[2]) ev[m_tag[2]] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("resp_valid", 64'(resp_valid), 64'(ev));
    chk("busy", 64'(busy), 64'(m_v[0] | m_v[1] | m_v[2]));
    if (m_v[2]) chk("resp_data", 64'(resp_data), 64'(m_res[2]));
  endtask

  task automatic model_update();
    int w;
    w = ref_winner();
    if (!ref_stall()) begin
      if (m_v[2]) m_out[m_tag[2]] = 0;
      for (int s = 2; s > 0; s--) begin
        m_v[s] = m_v[s-1]; m_tag[s] = m_tag[s-1]; m_res[s] = m_res[s-1];
      end
      if (w >= 0) begin
        m_v[0]   = 1;
        m_tag[0] = w;
        m_res[0] = ref_mul(req_a[w*DW +: DW], req_b[w*DW +: DW]);
        m_out[w] = 1;
        m_last   = w;
      end else begin
        m_v[0] = 0;
      end
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    check_outputs();
    obs_ready  = req_ready;
    obs_rvalid = resp_valid;
    obs_rdata  = resp_data;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = $urandom;
      req_b[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 4096)) - 32'd2048;
    end
  endtask

  task automatic drain(int cycles);
    req_valid  = '0;
    resp_ready = '1;
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic run_op(string tag, int r, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] expv);
    bit got;
    int lat;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_a[r*DW +: DW] = a;
    req_b[r*DW +: DW] = b;
    resp_ready = '1;
    got = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      step();
      if (obs_ready[r]) got = 1;
    end
    chk({tag, "_accept"}, 64'(got), 64'(1));
    req_valid[r] = 1'b0;
    got = 0; lat = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      step();
      lat++;
      if (obs_rvalid[r]) got = 1;
    end
    chk({tag, "_resp_seen"}, 64'(got), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(3));
    chk({tag, "_data"}, 64'(obs_rdata), 64'(expv));
    step();
    chk({tag, "_one_cycle"}, 64'(obs_rvalid), 64'(0));
  endtask

  initial begin
    int acc_tag[$], acc_cyc[$], rsp_tag[$], rsp_cyc[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] held;

    // Reset state, with requests pending to show req_ready is held off.
    rst_n = 1'b0;
    req_valid = '1; resp_ready = '1; req_a = '0; req_b = '0;
    model_reset();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin with every requester permanently requesting.
    req_valid = '1; resp_ready = '1;
    for (int c = 0; c < 12; c++) begin
      rand_operands();
      step();
      for (int i = 0; i < N; i++) begin
        if (obs_ready[i] && req_valid[i]) begin acc_tag.push_back(i); acc_cyc.push_back(c); end
        if (obs_rvalid[i]) begin rsp_tag.push_back(i); rsp_cyc.push_back(c); end
      end
    end
    chk("rr_accepts", 64'(acc_tag.size() >= 5), 64'(1));
    chk("rr_resps", 64'(rsp_tag.size() >= 4), 64'(1));
    for (int k = 0; k < 5 && k < acc_tag.size(); k++) begin
      chk("rr_grant_tag", 64'(acc_tag[k]), 64'(exp_rr[k]));
      chk("rr_grant_cycle", 64'(acc_cyc[k]), 64'(k));
    end
    for (int k = 0; k < 4 && k < rsp_tag.size(); k++) begin
      chk("rr_resp_tag", 64'(rsp_tag[k]), 64'(k));
      chk("rr_resp_cycle", 64'(rsp_cyc[k]), 64'(3 + k));
    end
    drain(8);

    // Directed arithmetic: scaling, sign and floor rounding.
    run_op("single", 0, 32'h0000_0400, 32'h0000_0200, 32'h0000_0200);
    run_op("neg",    0, 32'hFFFF_FC00, 32'h0000_0300, 32'hFFFF_FD00);
    run_op("floor",  0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);

    // Backpressure on requester 1 with 1,2,3 in flight; 0 waits behind the stall.
    rand_operands();
    req_valid = 4'b1110; resp_ready = 4'b1101;
    for (int c = 0; c < 3; c++) step();
    req_valid = 4'b0001;
    step();
    held = obs_rdata;
    chk("bp_resp_valid", 64'(obs_rvalid), 64'(4'b0010));
    chk("bp_req_ready", 64'(obs_ready), 64'(0));
    for (int c = 0; c < 9; c++) begin
      rand_operands();
      step();
      chk("bp_hold_valid", 64'(obs_rvalid), 64'(4'b0010));
      chk("bp_hold_data", 64'(obs_rdata), 64'(held));
      chk("bp_hold_ready", 64'(obs_ready), 64'(0));
    end
    resp_ready = '1;
    step();
    chk("bp_rel_1", 64'(obs_rvalid), 64'(4'b0010));
    chk("bp_rel_data", 64'(obs_rdata), 64'(held));
    req_valid = '0;
    step();
    chk("bp_rel_2", 64'(obs_rvalid), 64'(4'b0100));
    step();
    chk("bp_rel_3", 64'(obs_rvalid), 64'(4'b1000));
    drain(8);

    // Outstanding lockout: requester 2 holds valid continuously.
    acc_cyc.delete(); rsp_cyc.delete();
    req_valid = 4'b0100; resp_ready = '1;
    for (int c = 0; c < 20; c++) begin
      rand_operands();
      step();
      if (obs_ready[2]) acc_cyc.push_back(c);
      if (obs_rvalid[2]) rsp_cyc.push_back(c);
    end
    chk("lock_accepts", 64'(acc_cyc.size() >= 4), 64'(1));
    for (int k = 0; k + 1 < acc_cyc.size() && k < rsp_cyc.size(); k++) begin
      chk("lock_resp_lat", 64'(rsp_cyc[k] - acc_cyc[k]), 64'(3));
      chk("lock_regrant", 64'(acc_cyc[k+1]), 64'(rsp_cyc[k] + 1));
    end
    drain(8);

    // Random traffic and backpressure against the reference model.
    for (int c = 0; c < 400; c++) begin
      rand_operands();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(10);

    // Asynchronous reset with three operations in flight.
    rand_operands();
    req_valid = 4'b0111; resp_ready = '1;
    for (int c = 0; c < 3; c++) step();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_resp_valid", 64'(resp_valid), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(0));
    chk("arst_resp_data", 64'(resp_data), 64'(0));
    model_reset();
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("post_rst_no_resp", 64'(obs_rvalid), 64'(0));
    end
    req_valid = '1;
    step();
    chk("post_rst_first_grant", 64'(obs_ready), 64'(4'b0001));
    drain(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter that shares one pipelined signed fixed-point multiplier among up to NUM_REQ requesters in the FM demodulation datapath, replacing per-stage multiplier instances such as pilot squaring, L-R merge and left/right volume gain. Each requester presents operands with a valid/ready handshake. It receives its quantized product back through a per-requester valid/ready response. At most one operation per requester is in flight, so responses are never reordered for any requester.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8
- DATA_WIDTH, default 32: operand and result width, two's complement
- QUANT_BITS, default 10: fractional bits; product is arithmetic-shifted right by this amount

- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- req_valid  in  NUM_REQ  requester i has operands on its slice
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand B; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot or zero; request i is accepted on an edge where req_valid[i] & req_ready[i]
- resp_valid  out  NUM_REQ  one-hot or zero; result for requester i is on resp_data
- resp_data  out  DATA_WIDTH  quantized product, shared by all requesters
- resp_ready  in  NUM_REQ  requester i consumes the result on an edge where resp_valid[i] & resp_ready[i]
- busy  out  1  any pipeline stage or the output register holds an operation

## Operation
- Pipeline:
  - S1: registered operands plus requester tag.
  - S2: registered full 2*DATA_WIDTH signed product plus tag.
  - OUT: registered result plus tag.
  - Each stage has a valid bit.
- Arithmetic: result = low DATA_WIDTH bits of (signed(a) * signed(b)) >>> QUANT_BITS.
  - Rounding is floor (truncation toward −inf).
  - No saturation; overflow wraps.
- outstanding[i] flag:
  - Set on acceptance of a request from i.
  - Cleared on the response handshake for i.
  - A requester with outstanding[i]=1 is never granted.
- Eligibility: eligible[i] = req_valid[i] & ~outstanding[i], using registered outstanding.
- Round-robin:
  - Pointer last holds the index of the most recent accepted grant; reset value NUM_REQ-1, so requester 0 wins first.
  - The winner is the first eligible index searching last+1, last+2, … modulo NUM_REQ.
  - last updates only on an accepted grant.
- Stall: stall = OUT.valid & ~resp_ready[OUT.tag].
  - While stalled, S1, S2 and OUT hold, and req_ready is all zero.
  - When not stalled, every stage advances each cycle. Bubbles propagate; they are not collapsed.
- req_ready[winner] = ~stall. req_ready is combinational from registered state and req_valid; it has no path from resp_ready other than through stall.
- resp_valid[i] = OUT.valid & (OUT.tag == i). resp_data holds OUT.data and is stable while resp_valid is held.
- busy = S1.valid | S2.valid | OUT.valid.

## Timing
- Reset values: req_ready 0 while reset is asserted; resp_valid 0, resp_data 0, busy 0. All valid bits, outstanding, tags and data are 0; last = NUM_REQ-1.
- Latency: accept on edge E0 → S1 valid after E0 → S2 after E1 → resp_valid high after E2. The result is visible in the 3rd cycle after the accept cycle.
- Throughput: one accepted operation per cycle with no stall. A single requester can issue at most one operation per 3 cycles plus its response delay.
- Simultaneous response handshake and new req_valid from the same requester: no grant that cycle, because outstanding is still set. Grant is possible from the next cycle.
- All requesters idle: req_ready stays 0 and last is unchanged.
- resp_ready held low indefinitely: the pipeline freezes with no loss, no duplicate, and no change to resp_data.
- resp_ready[j] for j ≠ OUT.tag is ignored.
- Reset asserted mid-operation: all in-flight operations are discarded and no response is emitted after reset release. Requesters must reissue.

## Test plan
- Single op: requester 0, a=0x00000400, b=0x00000200, resp_ready=1 → req_ready[0]=1 in the accept cycle; resp_valid[0] and resp_data=0x00000200 in the 3rd cycle after accept, for one cycle.
- Sign and floor: a=0xFFFFFC00, b=0x00000300 → 0xFFFFFD00. a=0xFFFFFFFF, b=0x00000001 → 0xFFFFFFFF.
- Round-robin: all four req_valid held high, resp_ready all 1 → grant order 0,1,2,3, then 0 again only after its response handshake. Four consecutive accepts; responses appear in tag order 0,1,2,3 on consecutive cycles.
- Backpressure: resp_ready[1]=0 for 10 cycles while ops 1,2,3 are in flight → resp_valid[1] held, resp_data stable, req_ready all 0. On release, responses 1,2,3 follow on consecutive cycles.
- Outstanding lockout: requester 2 keeps req_valid=1 → it is accepted only on the cycle after each resp handshake; no second accept before that.
- Async reset: assert reset low mid-flight with 3 ops in the pipeline → busy and resp_valid drop to 0 immediately. After release, no stale response appears, and requester 0 wins the next grant.
